// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with a shadow scoreboard.
// Optional perf counters: define FWD_PERF_CNT_EN.
module fwd_hazard_unit #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 2,
  parameter int RDY_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_wr_en,
  input  logic [TAG_W-1:0]         id_wr_tag,
  input  logic [RDY_W-1:0]         id_rdy_stage,
  input  logic [NUM_RD-1:0]        id_rd_en,
  input  logic [NUM_RD*TAG_W-1:0]  id_rd_tag,
  input  logic [DEPTH*DATA_W-1:0]  stage_data,
  input  logic                     flush,
  output logic [NUM_RD-1:0]        rd_fwd_en,
  output logic [NUM_RD*DATA_W-1:0] rd_fwd_data,
  output logic                     stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_fwd_cnt
`endif
);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [RDY_W-1:0] rdy;
  } sb_t;

  sb_t [DEPTH-1:0]         sb;
  sb_t                     ins;
  logic [NUM_RD-1:0]       fwd_en;
  logic [NUM_RD*DATA_W-1:0] fwd_data;
  logic [NUM_RD-1:0]       port_stall;
  logic                    stall_raw;

  // Per-port scan from oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_en     = '0;
    fwd_data   = '0;
    port_stall = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (id_rd_en[p] && sb[k].vld &&
            sb[k].tag == id_rd_tag[p*TAG_W +: TAG_W]) begin
          if (k >= int'(sb[k].rdy)) begin
            fwd_en[p]                     = 1'b1;
            fwd_data[p*DATA_W +: DATA_W]  = stage_data[k*DATA_W +: DATA_W];
            port_stall[p]                 = 1'b0;
          end else begin
            fwd_en[p]                     = 1'b0;
            fwd_data[p*DATA_W +: DATA_W]  = '0;
            port_stall[p]                 = 1'b1;
          end
        end
      end
    end
  end

  // Hazard decision and the entry that enters EX next cycle.
  always_comb begin
    stall_raw = id_valid & ~flush & (|port_stall);
    ins.vld   = id_valid & id_wr_en & ~stall_raw & ~flush;
    ins.tag   = id_wr_tag;
    ins.rdy   = id_rdy_stage;
  end

  // Outputs are held quiet while reset is asserted.
  always_comb begin
    rd_fwd_en   = rst ? fwd_en   : '0;
    rd_fwd_data = rst ? fwd_data : '0;
    stall       = rst & stall_raw;
  end

  // Scoreboard shift: insert at EX, retire past WB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sb <= '0;
    end else begin
      sb[0] <= ins;
      for (int k = 1; k < DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Saturating event counters, frozen while decode is flushed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else if (!flush) begin
      if (stall && perf_stall_cnt != '1) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if ((|rd_fwd_en) && perf_fwd_cnt != '1) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit.
// Reference model tracks issued instructions by age.
module tb_fwd_hazard_unit;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 3;
  localparam int NUM_RD = 2;
  localparam int RDY_W  = 2;

  localparam logic [3:0] R1 = 4'd1, R2 = 4'd2, R3 = 4'd3;
  localparam logic [3:0] R4 = 4'd4, R5 = 4'd5, R6 = 4'd6;
  localparam logic [3:0] R7 = 4'd7, IH = 4'd8, SP = 4'd9;

  logic                     clk;
  logic                     rst;
  logic                     id_valid;
  logic                     id_wr_en;
  logic [TAG_W-1:0]         id_wr_tag;
  logic [RDY_W-1:0]         id_rdy_stage;
  logic [NUM_RD-1:0]        id_rd_en;
  logic [NUM_RD*TAG_W-1:0]  id_rd_tag;
  logic [DEPTH*DATA_W-1:0]  stage_data;
  logic                     flush;
  logic [NUM_RD-1:0]        rd_fwd_en;
  logic [NUM_RD*DATA_W-1:0] rd_fwd_data;
  logic                     stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]              perf_stall_cnt;
  logic [31:0]              perf_fwd_cnt;
  logic [31:0]              m_stall_cnt;
  logic [31:0]              m_fwd_cnt;
`endif

  fwd_hazard_unit #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
    .NUM_RD(NUM_RD), .RDY_W(RDY_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_wr_en(id_wr_en),
    .id_wr_tag(id_wr_tag), .id_rdy_stage(id_rdy_stage),
    .id_rd_en(id_rd_en), .id_rd_tag(id_rd_tag),
    .stage_data(stage_data), .flush(flush),
    .rd_fwd_en(rd_fwd_en), .rd_fwd_data(rd_fwd_data),
    .stall(stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         writes;
    logic [3:0] tag;
    int         latency;
  } instr_t;

  // hist[a] = instruction that left decode a+1 cycles ago.
  instr_t hist[$];

  int n_asserts = 0;
  int n_fail    = 0;

  logic [NUM_RD-1:0]        e_en;
  logic [NUM_RD*DATA_W-1:0] e_data;
  logic                     e_stall;

  task automatic chk(string nm, logic [63:0] obs, logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Youngest in-flight producer decides: ready if old enough, else stall.
  task automatic model_eval();
    bit want_stall;
    want_stall = 0;
    e_en   = '0;
    e_data = '0;
    if (rst) begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (id_rd_en[p]) begin
          for (int a = 0; a < hist.size(); a++) begin
            if (hist[a].writes && hist[a].tag == id_rd_tag[p*TAG_W +: TAG_W]) begin
              if (a >= hist[a].latency) begin
                e_en[p] = 1'b1;
                e_data[p*DATA_W +: DATA_W] = stage_data[a*DATA_W +: DATA_W];
              end else begin
                want_stall = 1;
              end
              break;
            end
          end
        end
      end
    end
    e_stall = rst & id_valid & ~flush & want_stall;
  endtask

  task automatic model_advance();
    instr_t it;
    if (!rst) begin
      hist.delete();
    end else begin
      it.writes  = id_valid & id_wr_en & ~e_stall & ~flush;
      it.tag     = id_wr_tag;
      it.latency = int'(id_rdy_stage);
      hist.push_front(it);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
`ifdef FWD_PERF_CNT_EN
    if (!rst) begin
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
    end else if (!flush) begin
      if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if ((|e_en) && m_fwd_cnt != 32'hFFFF_FFFF) m_fwd_cnt++;
    end
`endif
  endtask

  // Check outputs against the model, then clock once.
  task automatic cycle(string nm);
    #1;
    model_eval();
    chk({nm, ".en"},    64'(rd_fwd_en),   64'(e_en));
    chk({nm, ".data"},  64'(rd_fwd_data), 64'(e_data));
    chk({nm, ".stall"}, 64'(stall),       64'(e_stall));
    @(posedge clk);
    model_advance();
    #1;
`ifdef FWD_PERF_CNT_EN
    chk({nm, ".pstall"}, 64'(perf_stall_cnt), 64'(m_stall_cnt));
    chk({nm, ".pfwd"},   64'(perf_fwd_cnt),   64'(m_fwd_cnt));
`endif
    @(negedge clk);
  endtask

  task automatic drive(logic v, logic we, logic [3:0] wt, logic [1:0] rdy,
                       logic [1:0] re, logic [3:0] t0, logic [3:0] t1,
                       logic fl);
    id_valid     = v;
    id_wr_en     = we;
    id_wr_tag    = wt;
    id_rdy_stage = rdy;
    id_rd_en     = re;
    id_rd_tag    = {t1, t0};
    flush        = fl;
  endtask

  task automatic set_sd(logic [15:0] d0, logic [15:0] d1, logic [15:0] d2);
    stage_data = {d2, d1, d0};
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 1, R3, 0, 2'b11, R3, R4, 0);
    set_sd(16'h1111, 16'h2222, 16'h3333);
    // reset asserted: everything quiet
    #1;
    chk("rst.stall", 64'(stall), 64'd0);
    cycle("rst");
    rst = 1'b1;
    drive(1, 0, R0(), 0, 2'b11, R3, R4, 0);
    cycle("post_rst");

    // ALU back-to-back
    drive(1, 1, R3, 0, 2'b00, R0(), R0(), 0);
    cycle("alu_prod");
    drive(1, 0, R0(), 0, 2'b01, R3, R0(), 0);
    set_sd(16'h1234, 16'h0000, 16'h0000);
    #1;
    chk("alu.en", 64'(rd_fwd_en), 64'h1);
    chk("alu.data", 64'(rd_fwd_data[15:0]), 64'h1234);
    chk("alu.stall", 64'(stall), 64'd0);
    cycle("alu_cons");

    // Load-use: exactly one stall cycle, then forward from stage 1
    drive(1, 1, R2, 1, 2'b00, R0(), R0(), 0);
    cycle("ld_prod");
    drive(1, 0, R0(), 0, 2'b01, R2, R0(), 0);
    #1;
    chk("lu.stall1", 64'(stall), 64'd1);
    cycle("lu_stall");
    set_sd(16'h0000, 16'hBEEF, 16'h0000);
    #1;
    chk("lu.stall2", 64'(stall), 64'd0);
    chk("lu.en", 64'(rd_fwd_en), 64'h1);
    chk("lu.data", 64'(rd_fwd_data[15:0]), 64'hBEEF);
    cycle("lu_fwd");

    // Youngest producer wins
    drive(1, 1, R5, 0, 2'b00, R0(), R0(), 0);
    cycle("y_old");
    cycle("y_new");
    drive(1, 0, R0(), 0, 2'b01, R5, R0(), 0);
    set_sd(16'h0002, 16'h0001, 16'h0000);
    #1;
    chk("young.data", 64'(rd_fwd_data[15:0]), 64'h0002);
    cycle("young");

    // WB-stage forward on port 0, stage 1 on port 1
    drive(1, 1, SP, 0, 2'b00, R0(), R0(), 0);
    cycle("sp_prod");
    drive(1, 1, IH, 0, 2'b00, R0(), R0(), 0);
    cycle("ih_prod");
    drive(1, 0, R0(), 0, 2'b00, R0(), R0(), 0);
    cycle("nop");
    drive(1, 0, R0(), 0, 2'b11, SP, IH, 0);
    set_sd(16'h0000, 16'h0080, 16'h7FFF);
    #1;
    chk("dual.en", 64'(rd_fwd_en), 64'h3);
    chk("dual.data", 64'(rd_fwd_data), 64'h0080_7FFF);
    cycle("dual");

    // Flush during load-use: no stall, bubble enters EX
    drive(1, 1, R2, 1, 2'b00, R0(), R0(), 0);
    cycle("fl_ld");
    drive(1, 1, R6, 0, 2'b01, R2, R0(), 1);
    #1;
    chk("flush.stall", 64'(stall), 64'd0);
    cycle("fl_stall");
    drive(1, 0, R0(), 0, 2'b11, R6, R2, 0);
    set_sd(16'h0000, 16'h5A5A, 16'h0000);
    #1;
    chk("flush.bubble", 64'(rd_fwd_en), 64'h2);
    cycle("fl_after");

    // Reset mid-operation drops all entries
    drive(1, 1, R1, 0, 2'b00, R0(), R0(), 0);
    cycle("f1");
    drive(1, 1, R4, 0, 2'b00, R0(), R0(), 0);
    cycle("f2");
    drive(1, 1, R7, 1, 2'b00, R0(), R0(), 0);
    cycle("f3");
    rst = 1'b0;
    drive(1, 0, R0(), 0, 2'b11, R1, R7, 0);
    #1;
    chk("mrst.en", 64'(rd_fwd_en), 64'd0);
    chk("mrst.stall", 64'(stall), 64'd0);
    cycle("mrst");
    rst = 1'b1;
    drive(1, 0, R0(), 0, 2'b11, R1, R4, 0);
    #1;
    chk("mrst.nohit", 64'(rd_fwd_en), 64'd0);
`ifdef FWD_PERF_CNT_EN
    chk("mrst.pcnt", 64'(perf_stall_cnt), 64'd0);
`endif
    cycle("mrst_a");
    drive(1, 0, R0(), 0, 2'b01, R7, R0(), 0);
    cycle("mrst_b");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0);
      stage_data = 48'({$urandom(), $urandom()});
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

  function automatic logic [3:0] R0();
    return 4'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined CPU; sits beside the ID stage and replaces per-stage ad-hoc bypass compares.
- Keeps its own shadow scoreboard of in-flight destination tags across DEPTH post-decode stages (EX, MEM, WB, ...).
- For each of NUM_RD decode read ports it selects forwarded data from the youngest producer, or raises a load-use stall when that producer's data is not yet available.
- Tag space covers R0-R7, IH, SP, T, RA.

Parameters:
- DATA_W, 16, datapath width.
- TAG_W, 4, destination/source tag width (R0-R7, IH, SP, T, RA encoded).
- DEPTH, 3, tracked post-decode stages; stage 0 = EX, stage DEPTH-1 = WB.
- NUM_RD, 2, number of decode read ports.
- RDY_W, 2, width of the ready-stage field; must satisfy 2^RDY_W >= DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- id_valid  in  1  decode holds a real instruction.
- id_wr_en  in  1  decode instruction writes a tag.
- id_wr_tag  in  TAG_W  destination tag.
- id_rdy_stage  in  RDY_W  first stage whose stage_data carries the result: 0 = ALU, 1 = load.
- id_rd_en  in  NUM_RD  per-port read enable.
- id_rd_tag  in  NUM_RD*TAG_W  packed source tags; port p is at bits [p*TAG_W +: TAG_W].
- stage_data  in  DEPTH*DATA_W  packed per-stage candidate writeback data from the pipeline.
- flush  in  1  squash the decode instruction (branch taken).
- rd_fwd_en  out  NUM_RD  forward hit per port.
- rd_fwd_data  out  NUM_RD*DATA_W  forwarded data, packed the same way as id_rd_tag.
- stall  out  1  freeze PC/IF/ID; bubble into EX.

Behaviour:
- Scoreboard: DEPTH entries {vld, tag, rdy_stage}. Reset (rst low at clk edge): all vld = 0.
- Every clock, entry k moves to k+1, and entry DEPTH-1 retires.
- Stage-0 insert:
  - The decode entry {id_valid & id_wr_en, id_wr_tag, id_rdy_stage} is inserted when stall = 0 and flush = 0.
  - Otherwise an invalid bubble is inserted; flush dominates stall.
- Lookup (combinational) per port p with id_rd_en[p] = 1:
  - Scan k = 0..DEPTH-1 for vld & tag == id_rd_tag[p]; the lowest k (youngest) wins, and older matches are ignored.
  - Hit and k >= rdy_stage: rd_fwd_en[p] = 1, rd_fwd_data[p] = stage_data[k].
  - Hit and k < rdy_stage: port stall request, rd_fwd_en[p] = 0, data 0.
  - No hit, or id_rd_en[p] = 0: rd_fwd_en[p] = 0, data 0; the register file value is used.
- stall = id_valid & ~flush & OR of the port stall requests. stall is purely combinational; no extra latency.
- Forwarding has zero-cycle latency; the same-cycle WB write is covered by stage DEPTH-1.
- Simultaneous read of the tag that decode is itself writing: no self-match, because the decode entry is not yet in the scoreboard.
- During reset, and in the cycle after it: all outputs 0, no stalls.
- Reset mid-stall drops all entries; a stall never persists across reset.
- Load-use with DEPTH = 3:
  - A consumer directly behind a load stalls exactly 1 cycle.
  - It then forwards from stage 1.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- When defined, two outputs are added:
  - perf_stall_cnt (32 bit): increments each cycle stall = 1.
  - perf_fwd_cnt (32 bit): increments each cycle any rd_fwd_en bit = 1.
- Both counters saturate at all-ones, reset to 0 and hold when flush = 1.
- When undefined, these ports and registers are absent, and the remaining behaviour is identical.

Test Plan:
- ALU back-to-back: ADDU writes R3 (rdy 0), stage_data[0] = 0x1234; next decode reads R3 on port 0 -> rd_fwd_en = 01, rd_fwd_data[0] = 0x1234, stall = 0.
- Load-use: LW writes R2 (rdy 1); next decode reads R2 -> stall = 1 for one cycle, then rd_fwd_en[0] = 1 with stage_data[1] = 0xBEEF, stall = 0.
- Youngest wins: R5 written by two consecutive ALU ops with stage_data[0] = 0x0002, stage_data[1] = 0x0001; read R5 -> 0x0002.
- WB forward and dual port: reads port 0 = SP and port 1 = IH, with SP at stage 2 (0x7FFF) and IH at stage 1 (0x0080) -> rd_fwd_en = 11, data 0x7FFF / 0x0080.
- Flush during stall: load-use stall with flush = 1 in the same cycle -> stall = 0, bubble inserted, and the next-cycle scoreboard stage 0 is invalid.
- Reset mid-operation: fill all 3 entries, then drive rst low for 1 cycle -> all outputs 0 and no hit on any previously written tag afterwards. With FWD_PERF_CNT_EN defined, perf_stall_cnt = 0.
